// File: rtl/breath_window_timer.sv
`default_nettype none
// ============================================================================
//  Module      : breath_window_timer
//  Description : Countdown LED bar and blowing-window pulse counter for the
//                spirometer game. Produces the latched win/lose verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
module breath_window_timer #(
  parameter int STEP_TICKS    = 1000,  // iCE ticks per countdown LED step
  parameter int WINDOW_TICKS  = 3000,  // iCE ticks in the blowing window
  parameter int TARGET_PULSES = 20     // pulses needed to win (1..255)
) (
  input  logic       iClk,
  input  logic       iReset,        // asynchronous, active-low
  input  logic       iCE,           // single-cycle timebase tick
  input  logic [1:0] ivState,       // game state from the game FSM
  input  logic       iSensor,       // raw airflow pulses, asynchronous
  output logic [3:0] ovLED,         // countdown bar, bit 3 leftmost
  output logic       oLED,          // OR of the bar; low = countdown done
  output logic       oLoser,        // window expired short of target
  output logic       oWinner,       // target reached inside the window
  output logic [7:0] ovPulseCount   // pulses counted this attempt
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // One tick counter serves both the countdown steps and the blowing window,
  // so it is sized for whichever of the two is longer.
  localparam int TICK_MAX = (STEP_TICKS > WINDOW_TICKS) ? STEP_TICKS : WINDOW_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);

  localparam logic [TICK_W-1:0] STEP_LAST   = TICK_W'(STEP_TICKS - 1);
  localparam logic [TICK_W-1:0] WINDOW_LAST = TICK_W'(WINDOW_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ZERO   = '0;
  localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);

  localparam logic [7:0] TARGET    = 8'(TARGET_PULSES);
  localparam logic [7:0] CNT_MAX   = 8'hFF;
  localparam logic [7:0] CNT_ZERO  = 8'h00;
  localparam logic [3:0] LED_FULL  = 4'b1111;
  localparam logic [3:0] LED_OFF   = 4'b0000;

  // Game-state encoding as driven by the upstream state machine
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_BLOW      = 2'd2,
    ST_LOST      = 2'd3
  } game_state_e;

  // --------------------------------------------------------------------------
  // Sensor conditioning: 2-flop synchronizer plus a third flop for edge detect
  // --------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic sens_prev_q;
  logic sens_edge;

  // Sensor sampling runs every clock, independent of the iCE timebase
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sens_prev_q <= 1'b0;
    end else begin
      sync1_q     <= iSensor;
      sync2_q     <= sync1_q;
      sens_prev_q <= sync2_q;
    end
  end

  // One detection per synchronized 0->1 transition
  assign sens_edge = sync2_q & ~sens_prev_q;

  // --------------------------------------------------------------------------
  // State-entry detection
  // --------------------------------------------------------------------------
  game_state_e state_cur;
  game_state_e prev_state_q;
  logic        entry_countdown;
  logic        entry_blow;

  assign state_cur = game_state_e'(ivState);

  // Remember last cycle's game state so entries can be recognised
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      prev_state_q <= ST_IDLE;
    end else begin
      prev_state_q <= state_cur;
    end
  end

  assign entry_countdown = (state_cur == ST_COUNTDOWN) && (prev_state_q != ST_COUNTDOWN);
  assign entry_blow      = (state_cur == ST_BLOW)      && (prev_state_q != ST_BLOW);

  // --------------------------------------------------------------------------
  // Timer, bar, counter and verdict registers
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_q,    tick_d;
  logic [3:0]        led_q,     led_d;
  logic              led_any_q, led_any_d;
  logic [7:0]        count_q,   count_d;
  logic              loser_q,   loser_d;
  logic              winner_q,  winner_d;

  logic [7:0] count_inc;
  logic       verdict;
  logic       win_now;
  logic       window_done;

  // Saturating increment; the verdict normally freezes the count well
  // before the ceiling, but a large target must never wrap to zero.
  assign count_inc   = (count_q == CNT_MAX) ? count_q : (count_q + 8'd1);
  assign verdict     = loser_q | winner_q;
  assign win_now     = sens_edge && (count_inc >= TARGET);
  assign window_done = iCE && (tick_q == WINDOW_LAST);

  // Next-state logic for the timer, LED bar, pulse counter and verdict flags
  always_comb begin
    tick_d   = tick_q;
    led_d    = led_q;
    count_d  = count_q;
    loser_d  = loser_q;
    winner_d = winner_q;

    case (state_cur)
      ST_IDLE: begin
        // Idle holds everything cleared, every clock
        tick_d   = TICK_ZERO;
        led_d    = LED_OFF;
        count_d  = CNT_ZERO;
        loser_d  = 1'b0;
        winner_d = 1'b0;
      end

      ST_COUNTDOWN: begin
        if (entry_countdown) begin
          led_d  = LED_FULL;
          tick_d = TICK_ZERO;
        end else if ((led_q != LED_OFF) && iCE) begin
          // Bar drains right with zero fill; timer stops once it is empty
          if (tick_q == STEP_LAST) begin
            tick_d = TICK_ZERO;
            led_d  = {1'b0, led_q[3:1]};
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      ST_BLOW: begin
        if (entry_blow) begin
          tick_d   = TICK_ZERO;
          count_d  = CNT_ZERO;
          loser_d  = 1'b0;
          winner_d = 1'b0;
          led_d    = LED_OFF;
        end else if (!verdict) begin
          if (sens_edge) begin
            count_d = count_inc;
          end
          if (iCE && !window_done) begin
            tick_d = tick_q + TICK_ONE;
          end
          // A win on the same edge as window expiry beats the loss
          if (win_now) begin
            winner_d = 1'b1;
          end else if (window_done) begin
            loser_d = 1'b1;
          end
        end
      end

      ST_LOST: begin
        // All outputs hold at their current values
      end

      default: begin
      end
    endcase

    led_any_d = |led_d;
  end

  // Register all outputs so nothing downstream sees combinational glitches
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      tick_q    <= TICK_ZERO;
      led_q     <= LED_OFF;
      led_any_q <= 1'b0;
      count_q   <= CNT_ZERO;
      loser_q   <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      led_q     <= led_d;
      led_any_q <= led_any_d;
      count_q   <= count_d;
      loser_q   <= loser_d;
      winner_q  <= winner_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ovLED        = led_q;
  assign oLED         = led_any_q;
  assign oLoser       = loser_q;
  assign oWinner      = winner_q;
  assign ovPulseCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_breath_window_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_breath_window_timer
//  Description : Self-checking bench for breath_window_timer using a vector
//                table for the winning attempt plus directed corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_breath_window_timer;

  localparam int STEP   = 4;
  localparam int WINDOW = 10;
  localparam int TARGET = 3;

  logic       iClk;
  logic       iReset;
  logic       iCE;
  logic [1:0] ivState;
  logic       iSensor;
  logic [3:0] ovLED;
  logic       oLED;
  logic       oLoser;
  logic       oWinner;
  logic [7:0] ovPulseCount;

  int n_cmp = 0;
  int n_bad = 0;

  breath_window_timer #(
    .STEP_TICKS   (STEP),
    .WINDOW_TICKS (WINDOW),
    .TARGET_PULSES(TARGET)
  ) dut (
    .iClk        (iClk),
    .iReset      (iReset),
    .iCE         (iCE),
    .ivState     (ivState),
    .iSensor     (iSensor),
    .ovLED       (ovLED),
    .oLED        (oLED),
    .oLoser      (oLoser),
    .oWinner     (oWinner),
    .ovPulseCount(ovPulseCount)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [1:0] st;
    logic       s;
    logic       ce;
    logic [3:0] led;
    logic       oled;
    logic       los;
    logic       win;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [0:23];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int led, input int oled,
                         input int los, input int win, input int cnt);
    chk({tag, "_led"},  ovLED,        led);
    chk({tag, "_oled"}, oLED,         oled);
    chk({tag, "_los"},  oLoser,       los);
    chk({tag, "_win"},  oWinner,      win);
    chk({tag, "_cnt"},  ovPulseCount, cnt);
  endtask

  // One clock: drive iCE, let the edge pass, sample 1 time unit later
  task automatic cyc(input logic ce);
    iCE = ce;
    @(posedge iClk);
    #1;
  endtask

  initial begin
    // Winning attempt: 3-clock pulses, latency of 3 edges, iCE on odd rows.
    //              st    s     ce    led   oled  los   win   cnt
    tbl[0]  = '{2'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{2'd2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{2'd2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{2'd2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[4]  = '{2'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[5]  = '{2'd2, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[6]  = '{2'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{2'd2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{2'd2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{2'd2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[10] = '{2'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[11] = '{2'd2, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[12] = '{2'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[13] = '{2'd2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[14] = '{2'd2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[15] = '{2'd2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[16] = '{2'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[17] = '{2'd2, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[18] = '{2'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[19] = '{2'd2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[20] = '{2'd2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[21] = '{2'd2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[22] = '{2'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[23] = '{2'd2, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3};

    // ---- Reset with the sensor held high, idle state ----
    iReset  = 1'b0;
    iCE     = 1'b0;
    iSensor = 1'b1;
    ivState = 2'd0;
    repeat (3) @(posedge iClk);
    #3;
    iReset = 1'b1;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'(i % 2));
      chk($sformatf("idle_cnt%0d", i), ovPulseCount, 0);
    end

    // ---- Countdown ----
    iSensor = 1'b0;
    ivState = 2'd1;
    cyc(1'b0);
    chk_all("cd_entry", 15, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0);
      cyc(1'b1);
      chk($sformatf("cd_led_k%0d", k), ovLED, 15 >> (k / 4));
      chk($sformatf("cd_oled_k%0d", k), oLED, (k < 16) ? 1 : 0);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'(i % 2));
      chk($sformatf("cd_hold_led%0d", i), ovLED, 0);
      chk($sformatf("cd_hold_oled%0d", i), oLED, 0);
    end

    // ---- Winning attempt from the vector table ----
    for (int i = 0; i < 24; i++) begin
      ivState = tbl[i].st;
      iSensor = tbl[i].s;
      cyc(tbl[i].ce);
      chk($sformatf("vec%0d_led", i),  ovLED,        tbl[i].led);
      chk($sformatf("vec%0d_oled", i), oLED,         tbl[i].oled);
      chk($sformatf("vec%0d_los", i),  oLoser,       tbl[i].los);
      chk($sformatf("vec%0d_win", i),  oWinner,      tbl[i].win);
      chk($sformatf("vec%0d_cnt", i),  ovPulseCount, tbl[i].cnt);
    end

    ivState = 2'd0;
    iSensor = 1'b0;
    cyc(1'b0);
    chk_all("win_to_idle", 0, 0, 0, 0, 0);

    // ---- Losing attempt: two pulses, then window expiry ----
    ivState = 2'd2;
    cyc(1'b0);
    for (int k = 1; k <= 10; k++) begin
      iSensor = (k == 1 || k == 2 || k == 5 || k == 6);
      cyc(1'b0);
      cyc(1'b1);
      chk($sformatf("lose_los_k%0d", k), oLoser, (k == 10) ? 1 : 0);
    end
    chk("lose_cnt", ovPulseCount, 2);
    chk("lose_win", oWinner, 0);

    // State 3 holds everything, even with a sensor pulse arriving
    ivState = 2'd3;
    iSensor = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'(i % 2));
    iSensor = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'(i % 2));
    chk_all("lost_hold", 0, 0, 1, 0, 2);

    ivState = 2'd0;
    cyc(1'b0);
    chk_all("lost_to_idle", 0, 0, 0, 0, 0);

    // ---- Third count on the same edge as the 10th iCE ----
    ivState = 2'd2;
    cyc(1'b0);
    for (int t = 1; t <= 20; t++) begin
      iSensor = (t <= 3) || (t >= 7 && t <= 9) || (t >= 17);
      cyc(1'(t % 2));
      if (t == 18) begin
        chk("tie_pre_win", oWinner, 0);
        chk("tie_pre_cnt", ovPulseCount, 2);
      end
      if (t == 19) begin
        chk("tie_win", oWinner, 1);
        chk("tie_los", oLoser, 0);
        chk("tie_cnt", ovPulseCount, 3);
      end
      if (t == 20) begin
        chk("tie_after_los", oLoser, 0);
      end
    end

    // ---- Asynchronous reset mid-countdown ----
    ivState = 2'd0;
    iSensor = 1'b0;
    cyc(1'b0);
    ivState = 2'd1;
    cyc(1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0);
      cyc(1'b1);
    end
    chk("pre_rst_led", ovLED, 3);
    chk("pre_rst_oled", oLED, 1);
    #2;
    iReset = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);

    ivState = 2'd2;
    @(posedge iClk);
    #3;
    iReset = 1'b1;
    #1;
    chk_all("rst_release", 0, 0, 0, 0, 0);
    for (int p = 1; p <= 3; p++) begin
      iSensor = 1'b1;
      repeat (3) cyc(1'b0);
      iSensor = 1'b0;
      repeat (3) cyc(1'b0);
      chk($sformatf("post_rst_cnt%0d", p), ovPulseCount, p);
      chk($sformatf("post_rst_win%0d", p), oWinner, (p == 3) ? 1 : 0);
      chk($sformatf("post_rst_los%0d", p), oLoser, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
